// File: rtl/tl_c_channel_sender.sv
// tl_c_channel_sender
//   TileLink C-channel message sequencer for the L1 data cache. Takes one
//   Release / ReleaseData / ProbeAck / ProbeAckData request carrying a full
//   cache line and emits it on the C channel as one or more DATA_BITS beats.
//   After a Release-type message it blocks new requests until the matching
//   ReleaseAck appears on D.
//
// Optional feature macro: TL_C_ACK_TIMEOUT_EN
//   Adds the TIMEOUT_CYCLES parameter and the err_timeout output. This is a
//   sticky flag that is raised when no matching ReleaseAck arrives within
//   TIMEOUT_CYCLES cycles of entering WAIT_ACK. The FSM then returns to IDLE
//   without pulsing release_done.
//
// Ports
//   clock, reset_n        : clock and synchronous active-low reset
//   req_*                 : request from the writeback/probe unit (valid/ready)
//   c_*                   : C-channel beat output (valid/ready), registered
//   d_valid/opcode/source : D-channel monitor (never backpressured)
//   release_done          : one-cycle pulse on the matching ReleaseAck
//   busy                  : high in any state other than IDLE
//   err_timeout           : (optional) ReleaseAck watchdog expiry, sticky

module tl_c_channel_sender #(
    parameter int SOURCE_BITS = 4,
    parameter int ADDR_BITS   = 32,
    parameter int SIZE_BITS   = 4,
    parameter int DATA_BITS   = 128,
    parameter int LINE_BYTES  = 64
`ifdef TL_C_ACK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                    clock,
    input  logic                    reset_n,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_opcode,
    input  logic [2:0]              req_param,
    input  logic [SIZE_BITS-1:0]    req_size,
    input  logic [SOURCE_BITS-1:0]  req_source,
    input  logic [ADDR_BITS-1:0]    req_address,
    input  logic [LINE_BYTES*8-1:0] req_data,
    input  logic                    req_corrupt,

    output logic                    c_valid,
    input  logic                    c_ready,
    output logic [2:0]              c_opcode,
    output logic [2:0]              c_param,
    output logic [SIZE_BITS-1:0]    c_size,
    output logic [SOURCE_BITS-1:0]  c_source,
    output logic [ADDR_BITS-1:0]    c_address,
    output logic [DATA_BITS-1:0]    c_data,
    output logic                    c_corrupt,

    input  logic                    d_valid,
    input  logic [3:0]              d_opcode,
    input  logic [SOURCE_BITS-1:0]  d_source,

    output logic                    release_done,
    output logic                    busy
`ifdef TL_C_ACK_TIMEOUT_EN
    ,
    output logic                    err_timeout
`endif
);

    localparam int BEAT_BYTES = DATA_BITS / 8;
    localparam int BEATS      = LINE_BYTES / BEAT_BYTES;
    localparam int LINE_BITS  = LINE_BYTES * 8;
    localparam int LG_BEAT    = $clog2(BEAT_BYTES);
    localparam int LG_BEATS   = $clog2(BEATS);
    localparam int CNT_W      = (LG_BEATS > 0) ? LG_BEATS : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ACK
    } state_t;

    state_t state_q, state_d;

    logic [2:0]             op_q;
    logic [2:0]             param_q;
    logic [SIZE_BITS-1:0]   size_q;
    logic [SOURCE_BITS-1:0] source_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [DATA_BITS-1:0]   data_q;
    logic [LINE_BITS-1:0]   line_q;     // beats not yet presented, LSB-aligned
    logic                   corrupt_q;
    logic                   is_rel_q;
    logic [CNT_W-1:0]       beat_q;
    logic [CNT_W-1:0]       last_q;
    logic                   release_done_q, release_done_d;

    logic [2:0]             op_eff;
    logic                   req_has_data;
    logic [31:0]            size_ext;
    logic [CNT_W-1:0]       beats_m1;
    logic                   accept;
    logic                   c_fire;
    logic                   last_fire;
    logic                   ack_match;
    logic                   timeout_hit;

    // Request decode: illegal opcodes become ProbeAck, and the beat count is
    // 2^size / beat bytes clamped to 1..BEATS (always 1 when there is no data).
    always_comb begin
        op_eff       = (req_opcode < 3'd4) ? 3'd4 : req_opcode;
        req_has_data = (op_eff == 3'd5) || (op_eff == 3'd7);
        size_ext     = 32'(req_size);
        if (!req_has_data || size_ext <= 32'(LG_BEAT)) begin
            beats_m1 = '0;
        end else if ((size_ext - 32'(LG_BEAT)) >= 32'(LG_BEATS)) begin
            beats_m1 = CNT_W'(BEATS - 1);
        end else begin
            beats_m1 = CNT_W'((32'd1 << (size_ext - 32'(LG_BEAT))) - 32'd1);
        end
    end

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign c_fire    = (state_q == ST_SEND) && c_ready;
    assign last_fire = c_fire && (beat_q == last_q);
    assign ack_match = d_valid && (d_opcode == 4'd6) && (d_source == source_q);

`ifdef TL_C_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    assign timeout_hit = (state_q == ST_WAIT_ACK) && !ack_match &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (last_fire && is_rel_q) begin
                to_cnt_q <= '0;
            end else if (state_q == ST_WAIT_ACK) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        release_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (last_fire) begin
                    state_d = is_rel_q ? ST_WAIT_ACK : ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_match) begin
                    state_d        = ST_IDLE;
                    release_done_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            release_done_q <= 1'b0;
            op_q           <= '0;
            param_q        <= '0;
            size_q         <= '0;
            source_q       <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            line_q         <= '0;
            corrupt_q      <= 1'b0;
            is_rel_q       <= 1'b0;
            beat_q         <= '0;
            last_q         <= '0;
        end else begin
            state_q        <= state_d;
            release_done_q <= release_done_d;
            if (accept) begin
                op_q      <= op_eff;
                param_q   <= req_param;
                size_q    <= req_size;
                source_q  <= req_source;
                addr_q    <= req_address;
                corrupt_q <= req_has_data && req_corrupt;
                is_rel_q  <= (op_eff == 3'd6) || (op_eff == 3'd7);
                beat_q    <= '0;
                last_q    <= beats_m1;
                if (req_has_data) begin
                    data_q <= req_data[DATA_BITS-1:0];
                    line_q <= req_data >> DATA_BITS;
                end else begin
                    data_q <= '0;
                    line_q <= '0;
                end
            end else if (c_fire) begin
                // The next beat is shifted into the output register so that
                // c_data is always a flop output.
                beat_q <= last_fire ? '0 : beat_q + 1'b1;
                data_q <= line_q[DATA_BITS-1:0];
                line_q <= line_q >> DATA_BITS;
            end
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign c_valid      = (state_q == ST_SEND);
    assign busy         = (state_q != ST_IDLE);
    assign release_done = release_done_q;
    assign c_opcode     = op_q;
    assign c_param      = param_q;
    assign c_size       = size_q;
    assign c_source     = source_q;
    assign c_address    = addr_q;
    assign c_data       = data_q;
    assign c_corrupt    = corrupt_q;

endmodule

// File: tb/tb_tl_c_channel_sender.sv
module tb_tl_c_channel_sender;

    localparam int DB = 128;
    localparam int LB = 64;
    localparam int NB = LB / (DB / 8);

    typedef struct packed {
        logic [2:0]   op;
        logic [2:0]   param;
        logic [3:0]   size;
        logic [3:0]   src;
        logic [31:0]  addr;
        logic [127:0] data;
        logic         corrupt;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_opcode = '0;
    logic [2:0]    req_param = '0;
    logic [3:0]    req_size = '0;
    logic [3:0]    req_source = '0;
    logic [31:0]   req_address = '0;
    logic [LB*8-1:0] req_data = '0;
    logic          req_corrupt = 1'b0;
    logic          c_valid;
    logic          c_ready = 1'b1;
    logic [2:0]    c_opcode;
    logic [2:0]    c_param;
    logic [3:0]    c_size;
    logic [3:0]    c_source;
    logic [31:0]   c_address;
    logic [DB-1:0] c_data;
    logic          c_corrupt;
    logic          d_valid = 1'b0;
    logic [3:0]    d_opcode = '0;
    logic [3:0]    d_source = '0;
    logic          release_done;
    logic          busy;
`ifdef TL_C_ACK_TIMEOUT_EN
    logic          err_timeout;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int done_exp = 0;
    beat_t exp_q[$];

    always #5 clock = ~clock;

    tl_c_channel_sender #(
        .SOURCE_BITS(4),
        .ADDR_BITS(32),
        .SIZE_BITS(4),
        .DATA_BITS(DB),
        .LINE_BYTES(LB)
`ifdef TL_C_ACK_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_opcode(req_opcode),
        .req_param(req_param),
        .req_size(req_size),
        .req_source(req_source),
        .req_address(req_address),
        .req_data(req_data),
        .req_corrupt(req_corrupt),
        .c_valid(c_valid),
        .c_ready(c_ready),
        .c_opcode(c_opcode),
        .c_param(c_param),
        .c_size(c_size),
        .c_source(c_source),
        .c_address(c_address),
        .c_data(c_data),
        .c_corrupt(c_corrupt),
        .d_valid(d_valid),
        .d_opcode(d_opcode),
        .d_source(d_source),
        .release_done(release_done),
        .busy(busy)
`ifdef TL_C_ACK_TIMEOUT_EN
        ,
        .err_timeout(err_timeout)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_beat(input logic [2:0] op, input logic [2:0] param, input logic [3:0] size,
                             input logic [3:0] src, input logic [31:0] addr,
                             input logic [127:0] data, input logic corrupt);
        beat_t b;
        b.op = op; b.param = param; b.size = size; b.src = src;
        b.addr = addr; b.data = data; b.corrupt = corrupt;
        exp_q.push_back(b);
    endtask

    // Reference model of the expected beats for one request.
    task automatic push_msg(input logic [2:0] op, input logic [2:0] param, input logic [3:0] size,
                            input logic [3:0] src, input logic [31:0] addr,
                            input logic [LB*8-1:0] line, input logic corrupt);
        logic [2:0] eop;
        logic hd;
        int n;
        logic [127:0] d;
        eop = (op < 3'd4) ? 3'd4 : op;
        hd = (eop == 3'd5) || (eop == 3'd7);
        n = 1;
        if (hd) begin
            n = (1 << size) / (DB / 8);
            if (n < 1) n = 1;
            if (n > NB) n = NB;
        end
        for (int k = 0; k < n; k++) begin
            d = hd ? line[k*DB +: DB] : '0;
            push_beat(eop, param, size, src, addr, d, hd && corrupt);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] param, input logic [3:0] size,
                         input logic [3:0] src, input logic [31:0] addr,
                         input logic [LB*8-1:0] line, input logic corrupt);
        bit fired = 0;
        req_opcode = op; req_param = param; req_size = size; req_source = src;
        req_address = addr; req_data = line; req_corrupt = corrupt;
        req_valid = 1'b1;
        for (int i = 0; i < 100 && !fired; i++) begin
            @(negedge clock);
            if (req_ready) fired = 1;
            step();
        end
        req_valid = 1'b0;
        if (!fired) begin
            n_tests++; n_fail++;
            $display("FAIL req_accept: got no accept expected accept within 100 cycles");
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (!busy && exp_q.size() == 0) ok = 1;
        end
        check(name, {127'd0, ok}, 128'd1);
    endtask

    task automatic wait_ack_state(input string name);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (busy && !c_valid && exp_q.size() == 0) ok = 1;
        end
        check(name, {127'd0, ok}, 128'd1);
    endtask

    task automatic send_ack(input logic [3:0] op, input logic [3:0] src);
        d_valid = 1'b1; d_opcode = op; d_source = src;
        step();
        d_valid = 1'b0;
    endtask

    // Scoreboard monitor: every C fire must match the head of exp_q, and every
    // release_done pulse must have been announced by the stimulus.
    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            if (c_valid && c_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL c_beat_unexpected: got op=%0d data=%h expected no beat", c_opcode, c_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt} !== e) begin
                        n_fail++;
                        $display("FAIL c_beat: got op=%0d param=%0d size=%0d src=%0d addr=%h data=%h corrupt=%0d expected op=%0d param=%0d size=%0d src=%0d addr=%h data=%h corrupt=%0d",
                                 c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
                                 e.op, e.param, e.size, e.src, e.addr, e.data, e.corrupt);
                    end
                end
            end
            if (release_done) begin
                n_tests++;
                if (done_exp > 0) done_exp--;
                else begin
                    n_fail++;
                    $display("FAIL release_done_unexpected: got 1 expected 0");
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LB*8-1:0] line_a, line_b;
        logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < LB; i++) begin
            line_a[i*8 +: 8] = 8'(i);
            line_b[i*8 +: 8] = 8'(8'hFF - i);
        end

        // Reset state
        reset_n = 1'b0;
        repeat (3) step();
        @(negedge clock);
        check("rst_c_valid", c_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_release_done", release_done, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_c_fields", {c_opcode, c_param, c_size, c_source, c_address, c_corrupt}, 0);
        check("rst_c_data", c_data, 0);
        step();
        reset_n = 1'b1;
        step();

        // ProbeAck: single dataless beat, one cycle after the fire
        push_beat(3'd4, 3'd3, 4'd6, 4'd2, 32'h1000, 128'd0, 1'b0);
        issue(3'd4, 3'd3, 4'd6, 4'd2, 32'h1000, line_b, 1'b1);
        @(negedge clock);
        check("pa_c_valid_after_fire", c_valid, 1);
        @(negedge clock);
        check("pa_c_valid_drop", c_valid, 0);
        check("pa_busy_idle", busy, 0);
        check("pa_no_release_done", release_done, 0);
        step();

        // ReleaseData, 4 beats, hand-computed beat contents
        push_beat(3'd7, 3'd1, 4'd6, 4'd2, 32'h2040, 128'h0F0E0D0C0B0A09080706050403020100, 1'b1);
        push_beat(3'd7, 3'd1, 4'd6, 4'd2, 32'h2040, 128'h1F1E1D1C1B1A19181716151413121110, 1'b1);
        push_beat(3'd7, 3'd1, 4'd6, 4'd2, 32'h2040, 128'h2F2E2D2C2B2A29282726252423222120, 1'b1);
        push_beat(3'd7, 3'd1, 4'd6, 4'd2, 32'h2040, 128'h3F3E3D3C3B3A39383736353433323130, 1'b1);
        issue(3'd7, 3'd1, 4'd6, 4'd2, 32'h2040, line_a, 1'b1);
        wait_ack_state("rd_reach_wait_ack");
        check("rd_wait_req_ready", req_ready, 0);
        step();
        done_exp++;
        send_ack(4'd6, 4'd2);
        @(negedge clock);
        check("rd_release_done", release_done, 1);
        check("rd_req_ready_after_ack", req_ready, 1);
        @(negedge clock);
        check("rd_release_done_pulse", release_done, 0);
        step();

        // ProbeAckData with c_ready toggling
        push_msg(3'd5, 3'd2, 4'd6, 4'd3, 32'h3000, line_b, 1'b0);
        issue(3'd5, 3'd2, 4'd6, 4'd3, 32'h3000, line_b, 1'b0);
        for (int i = 0; i < 7; i++) begin
            c_ready = pat[i];
            step();
        end
        c_ready = 1'b1;
        wait_idle("pad_all_beats");
        step();

        // Release: non-matching D beats ignored in WAIT_ACK
        push_msg(3'd6, 3'd0, 4'd6, 4'd2, 32'h4000, line_a, 1'b1);
        issue(3'd6, 3'd0, 4'd6, 4'd2, 32'h4000, line_a, 1'b1);
        wait_ack_state("rel_reach_wait_ack");
        step();
        send_ack(4'd6, 4'd5);
        send_ack(4'd1, 4'd2);
        @(negedge clock);
        check("rel_ignore_done", release_done, 0);
        check("rel_ignore_busy", busy, 1);
        step();
        done_exp++;
        send_ack(4'd6, 4'd2);
        @(negedge clock);
        check("rel_match_done", release_done, 1);
        step();

        // Illegal opcode, short size, size clamp
        push_msg(3'd2, 3'd1, 4'd6, 4'd7, 32'h5000, line_a, 1'b1);
        issue(3'd2, 3'd1, 4'd6, 4'd7, 32'h5000, line_a, 1'b1);
        wait_idle("illegal_op_one_beat");
        step();
        push_msg(3'd5, 3'd0, 4'd3, 4'd1, 32'h5100, line_b, 1'b1);
        issue(3'd5, 3'd0, 4'd3, 4'd1, 32'h5100, line_b, 1'b1);
        wait_idle("small_size_one_beat");
        step();
        push_msg(3'd5, 3'd0, 4'd5, 4'd1, 32'h5200, line_a, 1'b0);
        issue(3'd5, 3'd0, 4'd5, 4'd1, 32'h5200, line_a, 1'b0);
        wait_idle("size5_two_beats");
        step();
        push_msg(3'd5, 3'd0, 4'd9, 4'd1, 32'h5300, line_b, 1'b0);
        issue(3'd5, 3'd0, 4'd9, 4'd1, 32'h5300, line_b, 1'b0);
        wait_idle("size_clamp_four_beats");
        step();

        // Reset during the second beat of ReleaseData
        push_msg(3'd7, 3'd1, 4'd6, 4'd2, 32'h6000, line_a, 1'b0);
        issue(3'd7, 3'd1, 4'd6, 4'd2, 32'h6000, line_a, 1'b0);
        step();
        reset_n = 1'b0;
        c_ready = 1'b0;
        step();
        @(negedge clock);
        check("abort_c_valid", c_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_release_done", release_done, 0);
        exp_q.delete();
        step();
        reset_n = 1'b1;
        c_ready = 1'b1;
        step();
        push_msg(3'd4, 3'd3, 4'd6, 4'd9, 32'h7000, line_a, 1'b0);
        issue(3'd4, 3'd3, 4'd6, 4'd9, 32'h7000, line_a, 1'b0);
        wait_idle("post_abort_probeack");
        step();

`ifdef TL_C_ACK_TIMEOUT_EN
        push_msg(3'd6, 3'd0, 4'd6, 4'd4, 32'h8000, line_a, 1'b0);
        issue(3'd6, 3'd0, 4'd6, 4'd4, 32'h8000, line_a, 1'b0);
        wait_ack_state("to_reach_wait_ack");
        for (int i = 1; i < 16; i++) begin
            @(negedge clock);
            check("to_err_early", err_timeout, 0);
        end
        @(negedge clock);
        check("to_err_set", err_timeout, 1);
        check("to_idle", busy, 0);
        check("to_no_done", release_done, 0);
`endif

        repeat (3) @(negedge clock);
        check("done_pulses_seen", done_exp, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_c_channel_sender.md
Name: tl_c_channel_sender

Overview:
Parametrised TileLink C-channel message sequencer for the L1 data cache.
- Accepts one Release / ReleaseData / ProbeAck / ProbeAckData request carrying a full cache line.
- Emits the message on the C channel as one or more DATA_BITS beats under valid/ready.
- For Release-type messages, holds off further requests until the matching ReleaseAck arrives on D.
- Sits between the cache writeback/probe unit and the TileLink C/D ports.

Parameters:
SOURCE_BITS, 4, width of source id
ADDR_BITS, 32, width of address
SIZE_BITS, 4, width of lgSize field
DATA_BITS, 128, C-channel beat width (power of 2, at least 8)
LINE_BYTES, 64, cache line size in bytes (multiple of DATA_BITS/8)
TIMEOUT_CYCLES, 1024, ReleaseAck watchdog limit (optional feature only)

Ports:
clock  in  1  clock; all logic on the rising edge
reset_n  in  1  synchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_opcode  in  3  4=ProbeAck, 5=ProbeAckData, 6=Release, 7=ReleaseData
req_param  in  3  shrink/report permissions
req_size  in  SIZE_BITS  lgSize
req_source  in  SOURCE_BITS  source id
req_address  in  ADDR_BITS  line address
req_data  in  LINE_BYTES*8  line data; beat k = bits [k*DATA_BITS +: DATA_BITS]
req_corrupt  in  1  corrupt flag
c_valid  out  1  C beat valid
c_ready  in  1  C beat accepted
c_opcode, c_param, c_size, c_source, c_address  out  3/3/SIZE_BITS/SOURCE_BITS/ADDR_BITS  C header fields
c_data  out  DATA_BITS  beat data
c_corrupt  out  1  corrupt flag
d_valid  in  1  D beat valid (observed only; the block never backpressures D)
d_opcode  in  4  D opcode; 6 = ReleaseAck
d_source  in  SOURCE_BITS  D source id
release_done  out  1  one-cycle pulse when the matching ReleaseAck is received
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock `clock`; `reset_n` is synchronous and active-low.
- Reset values: state=IDLE, c_valid=0, release_done=0, busy=0, beat counter=0, and all C field registers 0.
- States:
  - IDLE: req_ready=1. On request fire, capture every req field and go to SEND. c_valid rises the cycle after the fire (1-cycle latency).
  - SEND: req_ready=0, c_valid=1. All C outputs are registered and held stable while c_valid && !c_ready. On each c fire, increment the beat counter. On the last beat fire:
    - opcode 6/7: go to WAIT_ACK.
    - opcode 4/5: go to IDLE; c_valid=0 the next cycle.
  - WAIT_ACK: req_ready=0, c_valid=0. When d_valid && d_opcode==6 && d_source==captured source: pulse release_done for one cycle, then go to IDLE. Non-matching D beats are ignored.
- hasData: true for opcodes 5 and 7 only.
- Beat count: B = LINE_BYTES/(DATA_BITS/8).
  - Data messages: N = 2^size/(DATA_BITS/8), clamped to the range 1..B.
  - Dataless messages: N = 1.
- c_data on beat k = captured line data [k*DATA_BITS +: DATA_BITS]. Dataless messages drive c_data=0.
- c_corrupt = captured corrupt for data messages, 0 for dataless.
- c_opcode, c_param, c_size, c_source and c_address are identical on every beat; the address does not increment.
- Invalid req_opcode (0–3) is accepted and sent as a single beat with c_opcode forced to 4 (ProbeAck).
- No new request can be accepted in the same cycle as a last-beat fire; req_ready rises only once IDLE is entered.
- A ReleaseAck arriving while in SEND is ignored; the ack is not buffered.
- Reset asserted mid-message: abort. Next cycle c_valid=0 and state=IDLE; no release_done pulse.

Optional Feature:
Macro TL_C_ACK_TIMEOUT_EN.
- Defined:
  - Adds output err_timeout (1 bit, reset 0) and a counter that runs in WAIT_ACK.
  - If TIMEOUT_CYCLES cycles pass without a matching ack: err_timeout goes to 1 (sticky until reset) and state returns to IDLE, with no release_done pulse.
  - The counter clears when WAIT_ACK is entered.
- Undefined: no port and no counter; WAIT_ACK waits indefinitely.

Test Plan:
- ProbeAck (op 4, param 3, size 6, source 2, addr 0x1000), c_ready=1 → one beat: op 4, c_data=0, c_corrupt=0; c_valid high for exactly 1 cycle, the cycle after the request fire; back in IDLE with no release_done.
- ReleaseData (op 7, size 6, data bytes 0x00..0x3F), DATA_BITS=128 → 4 beats, beat k = bytes 16k..16k+15, same address on every beat. Then d_valid with op 6, source 2 → release_done pulses 1 cycle, req_ready=1 the next cycle.
- ProbeAckData with c_ready toggling 1,0,0,1,1,0,1 → exactly 4 beats delivered, outputs stable through every stall, no beat skipped or repeated.
- WAIT_ACK receives D op 6 with source 5, then op 1 with source 2 → both ignored; the later op 6 with source 2 → release_done.
- reset_n driven low during beat 2 of ReleaseData → c_valid=0 and busy=0 the next cycle; a following ProbeAck is sent normally.
- With TL_C_ACK_TIMEOUT_EN, TIMEOUT_CYCLES=16 and no ack → err_timeout=1 exactly 16 cycles after entering WAIT_ACK; state is IDLE.
